// File: rtl/orb_feature_buffer_if.sv
// orb_feature_buffer_if: feature stream, matcher handshake and read ports of orb_feature_buffer
//   slave  : buffer side; drives ready, valid_length, brief_data, location_data, busy
//   master : producer/matcher side; drives frame_start/end, feature_*, ready_ack,
//            brief_/location_ read requests and buf_release
interface orb_feature_buffer_if #(
  parameter int Pra_Brief_Width = 256,
  parameter int Pra_Loc_Width   = 32
);
  logic                       frame_start;
  logic                       frame_end;
  logic                       feature_en;
  logic [Pra_Brief_Width-1:0] feature_brief;
  logic [Pra_Loc_Width-1:0]   feature_location;
  logic                       ready;
  logic                       ready_ack;
  logic [15:0]                valid_length;
  logic                       brief_en;
  logic [15:0]                brief_address;
  logic [Pra_Brief_Width-1:0] brief_data;
  logic                       location_en;
  logic [15:0]                location_address;
  logic [Pra_Loc_Width-1:0]   location_data;
  logic                       buf_release;
  logic                       busy;
  modport slave (
    input  frame_start, frame_end, feature_en, feature_brief, feature_location, ready_ack,
           brief_en, brief_address, location_en, location_address, buf_release,
    output ready, valid_length, brief_data, location_data, busy
  );
  modport master (
    output frame_start, frame_end, feature_en, feature_brief, feature_location, ready_ack,
           brief_en, brief_address, location_en, location_address, buf_release,
    input  ready, valid_length, brief_data, location_data, busy
  );
endinterface

// File: rtl/orb_feature_buffer.sv
// orb_feature_buffer: per-frame store of BRIEF descriptors and {Y,X} locations feeding the matcher
//   clk_i, rst_i : clock and synchronous active-high reset
//   bus          : orb_feature_buffer_if.slave (feature stream, ready/ack, release, two read ports)
//   drop_count_o : saturating count of refused features, present only with ORB_BUFFER_DROP_COUNT_EN
module orb_feature_buffer #(
  parameter int Pra_Depth       = 1024,
  parameter int Pra_Brief_Width = 256,
  parameter int Pra_Loc_Width   = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  orb_feature_buffer_if.slave bus
`ifdef ORB_BUFFER_DROP_COUNT_EN
  ,
  output logic [15:0]         drop_count_o
`endif
);
  localparam int AW = (Pra_Depth > 1) ? $clog2(Pra_Depth) : 1;
  localparam logic [16:0] DEPTH = 17'(Pra_Depth);
  typedef enum logic [1:0] {IDLE, FILL, READY, LOCKED} state_e;
  state_e                     state_q;
  logic [16:0]                count_q, wr_ptr, count_d;
  logic                       ready_q, busy_q, we;
  logic [15:0]                len_q;
  logic [Pra_Brief_Width-1:0] brief_mem [Pra_Depth];
  logic [Pra_Loc_Width-1:0]   loc_mem [Pra_Depth];
  logic [Pra_Brief_Width-1:0] brief_q;
  logic [Pra_Loc_Width-1:0]   loc_q;
  // a start coinciding with an end is ignored, so only a lone start rewinds the pointer
  assign wr_ptr  = (bus.frame_start && !bus.frame_end) ? '0 : count_q;
  assign we      = state_q == FILL && bus.feature_en && wr_ptr < DEPTH && !rst_i;
  assign count_d = wr_ptr + 17'(we);
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      count_q <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      len_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.frame_start) begin
          state_q <= FILL;
          count_q <= '0;
        end
        FILL: begin
          count_q <= count_d;
          if (bus.frame_end) begin
            state_q <= (count_d != '0) ? READY : IDLE;
            ready_q <= count_d != '0;
            busy_q  <= count_d != '0;
            len_q   <= (count_d != '0) ? count_d[15:0] : len_q;
          end
        end
        READY: if (bus.ready_ack) begin
          state_q <= LOCKED;
          ready_q <= 1'b0;
        end
        default: if (bus.buf_release) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end
  always_ff @(posedge clk_i) begin
    if (we) begin
      brief_mem[wr_ptr[AW-1:0]] <= bus.feature_brief;
      loc_mem[wr_ptr[AW-1:0]]   <= bus.feature_location;
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      brief_q <= '0;
      loc_q   <= '0;
    end else begin
      if (bus.brief_en)
        brief_q <= ({1'b0, bus.brief_address} < DEPTH) ? brief_mem[bus.brief_address[AW-1:0]] : '0;
      if (bus.location_en)
        loc_q <= ({1'b0, bus.location_address} < DEPTH) ? loc_mem[bus.location_address[AW-1:0]] : '0;
    end
  end
  assign bus.ready         = ready_q;
  assign bus.busy          = busy_q;
  assign bus.valid_length  = len_q;
  assign bus.brief_data    = brief_q;
  assign bus.location_data = loc_q;
`ifdef ORB_BUFFER_DROP_COUNT_EN
  logic [15:0] drop_q;
  logic        drop;
  assign drop = bus.feature_en && (state_q == FILL ? wr_ptr >= DEPTH : state_q == READY || state_q == LOCKED);
  always_ff @(posedge clk_i) begin
    if (rst_i) drop_q <= '0;
    else if (state_q == IDLE && bus.frame_start) drop_q <= '0;
    else if (drop && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
  end
  assign drop_count_o = drop_q;
`endif
endmodule

// File: tb/tb_orb_feature_buffer.sv
// tb_orb_feature_buffer: directed scoreboard bench; DUT 0 has depth 1024, DUT 1 has depth 4
module tb_orb_feature_buffer;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic         fs[2], fe[2], fen[2], ack[2], ben[2], lden[2], rel[2];
  logic [255:0] fbr[2], bdat[2];
  logic [31:0]  floc[2], ldat[2];
  logic [15:0]  badr[2], ladr[2], vlen[2];
  logic         rdy[2], bsy[2];
  logic [255:0] bq[2][$];
  logic [31:0]  lq[2][$];
  int tests = 0, fails = 0;
  orb_feature_buffer_if ia ();
  orb_feature_buffer_if ib ();
  assign ia.frame_start = fs[0], ia.frame_end = fe[0], ia.feature_en = fen[0], ia.feature_brief = fbr[0],
         ia.feature_location = floc[0], ia.ready_ack = ack[0], ia.brief_en = ben[0], ia.brief_address = badr[0],
         ia.location_en = lden[0], ia.location_address = ladr[0], ia.buf_release = rel[0];
  assign ib.frame_start = fs[1], ib.frame_end = fe[1], ib.feature_en = fen[1], ib.feature_brief = fbr[1],
         ib.feature_location = floc[1], ib.ready_ack = ack[1], ib.brief_en = ben[1], ib.brief_address = badr[1],
         ib.location_en = lden[1], ib.location_address = ladr[1], ib.buf_release = rel[1];
  assign rdy[0] = ia.ready, bsy[0] = ia.busy, vlen[0] = ia.valid_length, bdat[0] = ia.brief_data, ldat[0] = ia.location_data;
  assign rdy[1] = ib.ready, bsy[1] = ib.busy, vlen[1] = ib.valid_length, bdat[1] = ib.brief_data, ldat[1] = ib.location_data;
`ifdef ORB_BUFFER_DROP_COUNT_EN
  logic [15:0] dca, dcb;
`endif
  orb_feature_buffer #(.Pra_Depth(1024)) u_a (.clk_i(clk), .rst_i(rst), .bus(ia)
`ifdef ORB_BUFFER_DROP_COUNT_EN
    , .drop_count_o(dca)
`endif
  );
  orb_feature_buffer #(.Pra_Depth(4)) u_b (.clk_i(clk), .rst_i(rst), .bus(ib)
`ifdef ORB_BUFFER_DROP_COUNT_EN
    , .drop_count_o(dcb)
`endif
  );
  function automatic logic [255:0] br(int k);
    logic [255:0] r;
    for (int j = 0; j < 8; j++) r[j*32 +: 32] = 32'hC0DE_0000 + 32'(k * 8 + j);
    return r;
  endfunction
  function automatic logic [31:0] loc(int k);
    return 32'(k + 1) * 32'h0001_0001;
  endfunction
  task automatic chk(string n, logic [255:0] a, logic [255:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  task automatic st(int d, logic r, logic b, logic [15:0] l);
    chk($sformatf("ready%0d", d), 256'(rdy[d]), 256'(r));
    chk($sformatf("busy%0d", d), 256'(bsy[d]), 256'(b));
    chk($sformatf("valid_length%0d", d), 256'(vlen[d]), 256'(l));
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      fs[d] = 0; fe[d] = 0; fen[d] = 0; ack[d] = 0; ben[d] = 0; lden[d] = 0; rel[d] = 0;
    end
  endtask
  task automatic feat(int d, int k);
    fen[d] = 1; fbr[d] = br(k); floc[d] = loc(k);
  endtask
  task automatic frame(int d, int n, int base);
    fs[d] = 1;
    tick();
    for (int i = 0; i < n; i++) begin
      feat(d, base + i);
      tick();
    end
    fe[d] = 1;
    tick();
  endtask
  task automatic rd_b(int d, logic [15:0] a, logic [255:0] e);
    ben[d] = 1; badr[d] = a; bq[d].push_back(e);
    tick();
  endtask
  task automatic rd_l(int d, logic [15:0] a, logic [31:0] e);
    lden[d] = 1; ladr[d] = a; lq[d].push_back(e);
    tick();
  endtask
  task automatic accept(int d);
    ack[d] = 1;
    tick();
  endtask
  for (genvar g = 0; g < 2; g++) begin : g_mon
    initial begin
      logic pb, pl;
      forever begin
        @(posedge clk);
        pb = ben[g];
        pl = lden[g];
        @(negedge clk);
        if (pb) begin
          if (bq[g].size() == 0) begin
            tests++; fails++;
            $display("FAIL brief_rd%0d: unexpected read data %0h", g, bdat[g]);
          end else chk($sformatf("brief_rd%0d", g), bdat[g], bq[g].pop_front());
        end
        if (pl) begin
          if (lq[g].size() == 0) begin
            tests++; fails++;
            $display("FAIL loc_rd%0d: unexpected read data %0h", g, ldat[g]);
          end else chk($sformatf("loc_rd%0d", g), 256'(ldat[g]), 256'(lq[g].pop_front()));
        end
      end
    end
  end
  initial begin
    for (int d = 0; d < 2; d++) begin
      fs[d] = 0; fe[d] = 0; fen[d] = 0; ack[d] = 0; ben[d] = 0; lden[d] = 0; rel[d] = 0;
      fbr[d] = '0; floc[d] = '0; badr[d] = '0; ladr[d] = '0;
    end
    repeat (3) tick();
    rst = 0;
    for (int d = 0; d < 2; d++) begin
      st(d, 0, 0, 0);
      chk($sformatf("rst_brief%0d", d), bdat[d], '0);
      chk($sformatf("rst_loc%0d", d), 256'(ldat[d]), '0);
    end
    frame(1, 6, 0);
    st(1, 1, 1, 4);
    accept(1);
    st(1, 0, 1, 4);
    for (int i = 0; i < 4; i++) rd_b(1, 16'(i), br(i));
    rd_b(1, 16'd4, '0);
    rd_l(1, 16'd3, loc(3));
    rd_l(1, 16'hFFFF, '0);
`ifdef ORB_BUFFER_DROP_COUNT_EN
    chk("drop_full", 256'(dcb), 256'd2);
`endif
    frame(0, 5, 0);
    st(0, 1, 1, 5);
    repeat (3) tick();
    chk("ready_level", 256'(rdy[0]), 256'd1);
    accept(0);
    st(0, 0, 1, 5);
    rd_b(0, 16'd2, br(2));
    for (int i = 0; i < 10; i++) begin
      rd_l(0, 16'(i % 5), loc(i % 5));
      chk("brief_hold", bdat[0], br(2));
    end
    tick();
    chk("loc_hold", 256'(ldat[0]), 256'(32'h0005_0005));
    rd_b(0, 16'd1024, '0);
    rd_l(0, 16'hFFFF, '0);
    feat(0, 100); fs[0] = 1;
    tick();
    feat(0, 101); fe[0] = 1;
    tick();
    feat(0, 102);
    tick();
    st(0, 0, 1, 5);
    rd_b(0, 16'd0, br(0));
    rd_l(0, 16'd0, loc(0));
`ifdef ORB_BUFFER_DROP_COUNT_EN
    chk("drop_locked", 256'(dca), 256'd3);
`endif
    rel[0] = 1;
    tick();
    st(0, 0, 0, 5);
    accept(0);
    st(0, 0, 0, 5);
    frame(0, 3, 20);
    st(0, 1, 1, 3);
    rel[0] = 1;
    tick();
    st(0, 1, 1, 3);
`ifdef ORB_BUFFER_DROP_COUNT_EN
    chk("drop_clear", 256'(dca), 256'd0);
`endif
    accept(0);
    rd_b(0, 16'd1, br(21));
    rd_b(0, 16'd3, br(3));
    rel[0] = 1;
    tick();
    frame(0, 0, 0);
    st(0, 0, 0, 3);
    repeat (2) tick();
    chk("empty_no_ready", 256'(rdy[0]), 256'd0);
    frame(0, 3, 30);
    st(0, 1, 1, 3);
    accept(0);
    rd_b(0, 16'd2, br(32));
    rd_l(0, 16'd0, loc(30));
    rel[0] = 1;
    tick();
    fs[0] = 1;
    tick();
    feat(0, 40);
    tick();
    feat(0, 41);
    tick();
    feat(0, 50); fs[0] = 1;
    tick();
    feat(0, 51); fs[0] = 1; fe[0] = 1;
    tick();
    st(0, 1, 1, 2);
    accept(0);
    rd_b(0, 16'd0, br(50));
    rd_b(0, 16'd1, br(51));
    rel[0] = 1;
    tick();
    fs[0] = 1;
    tick();
    feat(0, 60);
    tick();
    feat(0, 61); rst = 1;
    tick();
    rst = 0;
    st(0, 0, 0, 0);
    chk("rst_fill_brief", bdat[0], '0);
    chk("rst_fill_loc", 256'(ldat[0]), '0);
    frame(0, 2, 70);
    st(0, 1, 1, 2);
    rst = 1;
    tick();
    rst = 0;
    st(0, 0, 0, 0);
    frame(0, 1, 80);
    st(0, 1, 1, 1);
    accept(0);
    rd_b(0, 16'd0, br(80));
    rd_l(0, 16'd0, loc(80));
    repeat (2) tick();
    chk("queue_drain", 256'(bq[0].size() + bq[1].size() + lq[0].size() + lq[1].size()), '0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
